// File: rtl/arb_pkg.sv
// Shared constants and FSM state type for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_e;

endpackage

// File: rtl/rr_pick8.sv
// Combinational rotating-priority picker: first set request at or after ptr, wrapping.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [IDX_W-1:0]   idx
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [IDX_W-1:0]     off;

  always_comb begin
    any = |req;
    // Rotate so that requester ptr sits at bit 0.
    dbl = {req, req} >> ptr;
    rot = dbl[NUM_REQ-1:0];
    off = '0;
    // Descending scan so the lowest set bit wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off = IDX_W'(k);
      end
    end
    idx = ptr + off;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// 8-requester round-robin arbiter with hold limit and break-before-make grant handover.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic               timeout
);

  localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

  arb_state_e       state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [7:0]       hold_cnt_q;

  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic             owner_req;
  logic             hold_hit;
  logic             grant_end;

  rr_pick8 u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    owner_req = req[gnt_idx];
    hold_hit  = (hold_cnt_q == HoldLast);
    grant_end = done | ~owner_req | hold_hit;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      gnt_valid  <= 1'b0;
      gnt_idx    <= '0;
      gnt_onehot <= '0;
      timeout    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          timeout    <= 1'b0;
          hold_cnt_q <= '0;
          if (pick_any) begin
            state_q    <= GRANT;
            gnt_valid  <= 1'b1;
            gnt_idx    <= pick_idx;
            gnt_onehot <= NUM_REQ'(1) << pick_idx;
          end
        end
        GRANT: begin
          if (grant_end) begin
            state_q    <= IDLE;
            ptr_q      <= gnt_idx + IDX_W'(1);
            hold_cnt_q <= '0;
            gnt_valid  <= 1'b0;
            gnt_onehot <= '0;
            // Pulse only when the hold limit alone ended the grant.
            timeout    <= hold_hit & ~done & owner_req;
          end else begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench: directed scenarios plus random traffic against a scoreboard model.
module tb_rr_arbiter8;

  localparam int unsigned MaxHold = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic [7:0] req;
  logic       done;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic [7:0] gnt_onehot;
  logic       timeout;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic       v;
    logic [2:0] idx;
    logic [7:0] oh;
    logic       to;
  } out_t;

  out_t exp_q[$];

  rr_arbiter8 #(
    .MAX_HOLD (MaxHold)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .req        (req),
    .done       (done),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx),
    .gnt_onehot (gnt_onehot),
    .timeout    (timeout)
  );

  initial forever #5 sys_clk = ~sys_clk;

  // Reference model: owner is -1 when no grant is active; age counts completed grant cycles.
  int   m_owner = -1;
  int   m_ptr   = 0;
  int   m_age   = 0;
  int   m_last  = 0;
  bit   m_to    = 1'b0;

  always @(posedge sys_clk) begin
    out_t e;
    bit   lim;
    bit   found;
    int   cand;
    if (!sys_rst_n) begin
      m_owner = -1;
      m_ptr   = 0;
      m_age   = 0;
      m_last  = 0;
      m_to    = 1'b0;
    end else if (m_owner < 0) begin
      m_to  = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
        cand = (m_ptr + k) % 8;
        if (!found && req[cand]) begin
          found   = 1'b1;
          m_owner = cand;
          m_last  = cand;
          m_age   = 0;
        end
      end
    end else begin
      lim = (m_age + 1 == int'(MaxHold));
      if (done || !req[m_owner] || lim) begin
        m_to    = lim && !done && req[m_owner];
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
      end else begin
        m_age = m_age + 1;
      end
    end
    e.v   = (m_owner >= 0);
    e.idx = m_last[2:0];
    e.oh  = (m_owner >= 0) ? (8'(1) << m_owner) : 8'h00;
    e.to  = m_to;
    exp_q.push_back(e);
  end

  // Monitor: one expected output vector per clock edge.
  always @(negedge sys_clk) begin
    out_t e;
    out_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {gnt_valid, gnt_idx, gnt_onehot, timeout};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL scoreboard @%0t: got v=%0b idx=%0d oh=%h to=%0b, expected v=%0b idx=%0d oh=%h to=%0b",
                 $time, a.v, a.idx, a.oh, a.to, e.v, e.idx, e.oh, e.to);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic v, input logic [2:0] idx,
                         input logic to);
    chk({name, ".valid"}, 32'(gnt_valid), 32'(v));
    if (v) chk({name, ".idx"}, 32'(gnt_idx), 32'(idx));
    chk({name, ".onehot"}, 32'(gnt_onehot), v ? 32'(8'(1) << idx) : 32'h0);
    chk({name, ".timeout"}, 32'(timeout), 32'(to));
  endtask

  initial begin
    req       = 8'hFF;
    done      = 1'b0;
    sys_rst_n = 1'b0;

    // Reset held with all requests pending.
    repeat (3) begin
      @(negedge sys_clk);
      chk("reset_outputs", {19'd0, gnt_valid, gnt_idx, gnt_onehot, timeout}, 32'h0);
    end
    sys_rst_n = 1'b1;
    done      = 1'b1;
    @(negedge sys_clk);
    chk_out("first_grant", 1'b1, 3'd0, 1'b0);

    // Rotation through all requesters with one idle cycle between grants.
    for (int k = 1; k <= 8; k++) begin
      @(negedge sys_clk);
      chk_out("rotate_gap", 1'b0, 3'd0, 1'b0);
      @(negedge sys_clk);
      chk_out("rotate_grant", 1'b1, 3'(k % 8), 1'b0);
    end

    // Move ptr to 6 via a grant at 5, then check wrap and skip.
    req = 8'h20;
    @(negedge sys_clk);
    @(negedge sys_clk);
    chk_out("ptr6_setup", 1'b1, 3'd5, 1'b0);
    @(negedge sys_clk);
    req = 8'h05;
    @(negedge sys_clk);
    chk_out("wrap_grant", 1'b1, 3'd0, 1'b0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    chk_out("skip_grant", 1'b1, 3'd2, 1'b0);

    // Hold limit: owner keeps req, never asserts done.
    req  = 8'h00;
    done = 1'b0;
    @(negedge sys_clk);
    req = 8'h08;
    repeat (4) begin
      @(negedge sys_clk);
      chk_out("hold_active", 1'b1, 3'd3, 1'b0);
    end
    @(negedge sys_clk);
    chk_out("timeout_pulse", 1'b0, 3'd3, 1'b1);
    chk("timeout_idx_kept", 32'(gnt_idx), 32'd3);
    @(negedge sys_clk);
    chk_out("regrant_after_timeout", 1'b1, 3'd3, 1'b0);

    // done coinciding with the hold limit: no timeout.
    @(negedge sys_clk);
    @(negedge sys_clk);
    @(negedge sys_clk);
    done = 1'b1;
    @(negedge sys_clk);
    chk_out("simul_release", 1'b0, 3'd3, 1'b0);

    // Reset in the middle of a grant at index 5.
    done = 1'b0;
    req  = 8'h20;
    @(negedge sys_clk);
    chk_out("pre_reset_grant", 1'b1, 3'd5, 1'b0);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    chk("midgrant_reset", {19'd0, gnt_valid, gnt_idx, gnt_onehot, timeout}, 32'h0);
    sys_rst_n = 1'b1;
    req       = 8'h22;
    @(negedge sys_clk);
    chk_out("post_reset_scan", 1'b1, 3'd1, 1'b0);

    // Random traffic; requests change occasionally so grants run for a while.
    for (int n = 0; n < 3000; n++) begin
      @(negedge sys_clk);
      if ($urandom_range(3) == 0) req = 8'($urandom);
      done      = ($urandom_range(7) == 0);
      sys_rst_n = ($urandom_range(249) != 0);
    end
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("scoreboard_drained", 32'(exp_q.size() <= 1), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
